// File: rtl/track_cache_multi.sv
// Multi-drive floppy track cache: one on-chip track buffer per drive, filled from and
// written back to SD one sector at a time, with drives served round-robin.
module track_cache_multi #(
  parameter int unsigned DRIVES       = 2,
  parameter int unsigned SECS         = 13,
  parameter int unsigned TRACK_W      = 6,
  parameter int unsigned FLUSH_CYCLES = 2**22,
  localparam int unsigned DW          = (DRIVES > 1) ? $clog2(DRIVES) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DRIVES*TRACK_W-1:0]   track,
  input  logic [DRIVES-1:0]           img_mounted,
  input  logic [63:0]                 img_size,
  input  logic [DRIVES-1:0]           wprot,
  output logic [31:0]                 sd_lba,
  output logic [DRIVES-1:0]           sd_rd,
  output logic [DRIVES-1:0]           sd_wr,
  input  logic [DRIVES-1:0]           sd_ack,
  input  logic [8:0]                  sd_buff_addr,
  input  logic                        sd_buff_wr,
  input  logic [7:0]                  sd_buff_dout,
  output logic [7:0]                  sd_buff_din,
  input  logic [DW-1:0]               fd_drive,
  input  logic [12:0]                 fd_track_addr,
  input  logic                        fd_write_disk,
  input  logic [7:0]                  fd_data_do,
  output logic [7:0]                  fd_data_in,
  output logic [DRIVES-1:0]           cpu_wait
);

  localparam int unsigned IW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int unsigned AW = DW + 13;

  typedef enum logic [2:0] {StIdle, StWrite, StRstart, StRead, StAbort} state_t;

  state_t             state;
  logic [TRACK_W-1:0] cur_track [DRIVES];
  logic [IW-1:0]      idle      [DRIVES];
  logic [DRIVES-1:0]  dirty;
  logic [DRIVES-1:0]  valid;
  logic [DRIVES-1:0]  mount_pending;
  logic [DRIVES-1:0]  has_disk;
  logic [DW-1:0]      cur;
  logic [DW-1:0]      ptr;
  logic [3:0]         sec;
  logic               ack_prev;

  logic [TRACK_W-1:0] trk [DRIVES];
  logic [DRIVES-1:0]  need;
  logic [DRIVES-1:0]  flush_due;
  logic [DW-1:0]      pick;
  logic               pick_ok;
  logic               ack;
  logic               ack_rise;
  logic               ack_fall;
  logic               last_sec;
  logic               fd_wr_ok;
  logic               sd_fill;
  logic [AW-1:0]      fd_addr;
  logic [AW-1:0]      sd_addr;

  logic [7:0] ram [DRIVES*8192];

  assign ack      = sd_ack[cur];
  assign ack_rise = ack & ~ack_prev;
  assign ack_fall = ~ack & ack_prev;
  assign last_sec = (sec == 4'(SECS - 1));
  assign fd_wr_ok = fd_write_disk & ~wprot[fd_drive];
  assign sd_fill  = (state == StRead) & sd_buff_wr & sd_ack[cur];
  assign fd_addr  = {fd_drive, fd_track_addr};
  assign sd_addr  = {cur, sec, sd_buff_addr};

  always_comb begin
    for (int d = 0; d < DRIVES; d++) begin
      trk[d]       = track[d*TRACK_W +: TRACK_W];
      flush_due[d] = (FLUSH_CYCLES != 0) && dirty[d] && (idle[d] == IW'(FLUSH_CYCLES));
      // ~valid only fires together with mount_pending; kept as a safety net
      need[d]      = has_disk[d] & ((trk[d] != cur_track[d]) | mount_pending[d] |
                                    ~valid[d] | flush_due[d]);
    end
  end

  // Round-robin: scan from ptr upward, the lowest offset with a need wins.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int i = DRIVES - 1; i >= 0; i--) begin
      if (need[(int'(ptr) + i) % DRIVES]) begin
        pick_ok = 1'b1;
        pick    = DW'((int'(ptr) + i) % DRIVES);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= StIdle;
      sd_lba        <= '0;
      sd_rd         <= '0;
      sd_wr         <= '0;
      cpu_wait      <= '0;
      dirty         <= '0;
      valid         <= '0;
      mount_pending <= '0;
      has_disk      <= '0;
      cur           <= '0;
      ptr           <= '0;
      sec           <= '0;
      ack_prev      <= 1'b0;
      for (int d = 0; d < DRIVES; d++) begin
        cur_track[d] <= '0;
        idle[d]      <= '0;
      end
    end else begin
      ack_prev <= ack;

      for (int d = 0; d < DRIVES; d++) begin
        if (fd_wr_ok && fd_drive == DW'(d)) begin
          idle[d] <= '0;
        end else if (dirty[d] && idle[d] != IW'(FLUSH_CYCLES)) begin
          idle[d] <= idle[d] + IW'(1);
        end
      end

      unique case (state)
        StIdle: begin
          if (pick_ok) begin
            cur <= pick;
            ptr <= DW'((int'(pick) + 1) % DRIVES);
            sec <= '0;
            if (dirty[pick]) begin
              sd_lba         <= SECS * 32'(cur_track[pick]);
              sd_wr[pick]    <= 1'b1;
              cpu_wait[pick] <= 1'b1;
              state          <= StWrite;
            end else begin
              state <= StRstart;
            end
          end
        end

        StWrite: begin
          if (ack_rise) begin
            sd_lba <= sd_lba + 32'd1;
            if (last_sec) sd_wr[cur] <= 1'b0;
          end
          if (ack_fall) begin
            if (!last_sec) begin
              sec <= sec + 4'd1;
            end else begin
              dirty[cur] <= 1'b0;
              if (trk[cur] == cur_track[cur] && !mount_pending[cur]) begin
                cpu_wait[cur] <= 1'b0;
                state         <= StIdle;
              end else begin
                state <= StRstart;
              end
            end
          end
        end

        StRstart: begin
          cur_track[cur]     <= trk[cur];
          sec                <= '0;
          sd_lba             <= SECS * 32'(trk[cur]);
          sd_rd[cur]         <= 1'b1;
          cpu_wait[cur]      <= 1'b1;
          mount_pending[cur] <= 1'b0;
          state              <= StRead;
        end

        StRead: begin
          if (ack_rise) begin
            sd_lba <= sd_lba + 32'd1;
            if (last_sec) sd_rd[cur] <= 1'b0;
          end
          if (ack_fall) begin
            if (!last_sec) begin
              sec <= sec + 4'd1;
            end else begin
              valid[cur]    <= 1'b1;
              cpu_wait[cur] <= 1'b0;
              state         <= StIdle;
            end
          end
        end

        StAbort: begin
          if (!ack) state <= StIdle;
        end

        default: state <= StIdle;
      endcase

      // A floppy write landing in the same clock as the write-back clear keeps dirty set.
      if (fd_wr_ok) dirty[fd_drive] <= 1'b1;

      for (int d = 0; d < DRIVES; d++) begin
        if (img_mounted[d]) begin
          has_disk[d]      <= (img_size != 64'd0);
          mount_pending[d] <= (img_size != 64'd0);
          cpu_wait[d]      <= (img_size != 64'd0);
          valid[d]         <= 1'b0;
          if (cur == DW'(d) && state != StIdle && state != StAbort) begin
            sd_rd    <= '0;
            sd_wr    <= '0;
            dirty[d] <= 1'b0;
            state    <= StAbort;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fd_wr_ok) ram[fd_addr] <= fd_data_do;
    if (sd_fill)  ram[sd_addr] <= sd_buff_dout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fd_data_in  <= '0;
      sd_buff_din <= '0;
    end else begin
      fd_data_in  <= ram[fd_addr];
      sd_buff_din <= ram[sd_addr];
    end
  end

endmodule

// File: tb/tb_track_cache_multi.sv
// Directed bench for track_cache_multi: a small SD responder logs every sector request
// and captures write-back bytes; the main sequence checks against hand-computed values.
module tb_track_cache_multi;

  localparam int unsigned DRIVES  = 2;
  localparam int unsigned SECS    = 13;
  localparam int unsigned TRACK_W = 6;
  localparam int unsigned FLUSH   = 100;
  localparam int unsigned SIZE    = 143360;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [DRIVES*TRACK_W-1:0] track;
  logic [DRIVES-1:0]         img_mounted;
  logic [63:0]               img_size;
  logic [DRIVES-1:0]         wprot;
  logic [31:0]               sd_lba;
  logic [DRIVES-1:0]         sd_rd;
  logic [DRIVES-1:0]         sd_wr;
  logic [DRIVES-1:0]         sd_ack;
  logic [8:0]                sd_buff_addr;
  logic                      sd_buff_wr;
  logic [7:0]                sd_buff_dout;
  logic [7:0]                sd_buff_din;
  logic [0:0]                fd_drive;
  logic [12:0]               fd_track_addr;
  logic                      fd_write_disk;
  logic [7:0]                fd_data_do;
  logic [7:0]                fd_data_in;
  logic [DRIVES-1:0]         cpu_wait;

  track_cache_multi #(
    .DRIVES      (DRIVES),
    .SECS        (SECS),
    .TRACK_W     (TRACK_W),
    .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .track        (track),
    .img_mounted  (img_mounted),
    .img_size     (img_size),
    .wprot        (wprot),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_din  (sd_buff_din),
    .fd_drive     (fd_drive),
    .fd_track_addr(fd_track_addr),
    .fd_write_disk(fd_write_disk),
    .fd_data_do   (fd_data_do),
    .fd_data_in   (fd_data_in),
    .cpu_wait     (cpu_wait)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int onehot_bad = 0;
  bit sd_busy = 1'b0;
  bit log_wr [$];
  int log_drv [$];
  int log_lba [$];
  logic [7:0] wb [int];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int lba, input int a);
    return 8'(lba) ^ 8'(a) ^ 8'h3c;
  endfunction

  function automatic logic [8:0] addr_of(input int i);
    case (i)
      0:       return 9'h000;
      1:       return 9'h001;
      2:       return 9'h100;
      default: return 9'h1ff;
    endcase
  endfunction

  always @(negedge clk) if (!$onehot0({sd_rd, sd_wr})) onehot_bad++;

  // SD card model: services one sector per request, touching four byte positions.
  initial begin : sd_model
    bit         is_wr;
    int         drv;
    int         lba;
    logic [8:0] a;
    sd_ack       = '0;
    sd_buff_wr   = 1'b0;
    sd_buff_addr = '0;
    sd_buff_dout = '0;
    forever begin
      @(posedge clk); #1;
      if ((sd_rd | sd_wr) != '0 && !reset) begin
        sd_busy = 1'b1;
        is_wr   = |sd_wr;
        drv     = is_wr ? (sd_wr[0] ? 0 : 1) : (sd_rd[0] ? 0 : 1);
        lba     = int'(sd_lba);
        @(posedge clk); #1;
        sd_ack[drv] = 1'b1;
        for (int i = 0; i < 4; i++) begin
          a            = addr_of(i);
          sd_buff_addr = a;
          if (!is_wr) begin
            sd_buff_dout = pat(lba, int'(a));
            sd_buff_wr   = 1'b1;
          end
          @(posedge clk); #1;
          sd_buff_wr = 1'b0;
          if (is_wr) wb[lba*512 + int'(a)] = sd_buff_din;
        end
        sd_ack[drv] = 1'b0;
        log_wr.push_back(is_wr);
        log_drv.push_back(drv);
        log_lba.push_back(lba);
      end else begin
        sd_busy = 1'b0;
      end
    end
  end

  task automatic clear_log();
    log_wr.delete();
    log_drv.delete();
    log_lba.delete();
  endtask

  task automatic wait_log(input string tag, input int n);
    int k = 0;
    while (log_wr.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, log_wr.size(), n);
  endtask

  task automatic wait_ready(input string tag, input int d);
    int k = 0;
    while (cpu_wait[d] !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, cpu_wait[d], 0);
  endtask

  task automatic check_seq(input string tag, input int first, input int n, input bit wr,
                           input int drv, input int lba0);
    int ok = 0;
    for (int i = 0; i < n; i++) begin
      if (first + i < log_wr.size() && log_wr[first+i] == wr && log_drv[first+i] == drv &&
          log_lba[first+i] == lba0 + i) ok++;
    end
    check(tag, ok, n);
  endtask

  task automatic mount(input int d, input logic [63:0] size);
    @(negedge clk);
    img_size       = size;
    img_mounted[d] = 1'b1;
    @(negedge clk);
    img_mounted = '0;
  endtask

  task automatic fd_write(input int d, input int addr, input logic [7:0] data);
    @(negedge clk);
    fd_drive      = 1'(d);
    fd_track_addr = 13'(addr);
    fd_data_do    = data;
    fd_write_disk = 1'b1;
    @(negedge clk);
    fd_write_disk = 1'b0;
  endtask

  task automatic fd_read(input int d, input int addr, output logic [7:0] data);
    @(negedge clk);
    fd_drive      = 1'(d);
    fd_track_addr = 13'(addr);
    @(negedge clk);
    data = fd_data_in;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    logic [7:0] d8;
    int         cnt;
    reset         = 1'b0;
    track         = '0;
    img_mounted   = '0;
    img_size      = '0;
    wprot         = '0;
    fd_drive      = '0;
    fd_track_addr = '0;
    fd_write_disk = 1'b0;
    fd_data_do    = '0;
    #1 reset = 1'b1;
    #11;
    check("rst_lba", sd_lba, 0);
    check("rst_rd", sd_rd, 0);
    check("rst_wr", sd_wr, 0);
    check("rst_wait", cpu_wait, 0);
    check("rst_fd_data", fd_data_in, 0);
    check("rst_sd_din", sd_buff_din, 0);
    @(negedge clk) reset = 1'b0;

    // Initial load of drive 0, track 0: LBAs 0..12
    mount(0, SIZE);
    check("t1_wait_hi", cpu_wait[0], 1);
    wait_log("t1_len12", 12);
    check("t1_busy_before_last", cpu_wait[0], 1);
    wait_log("t1_len13", 13);
    check_seq("t1_seq", 0, 13, 1'b0, 0, 0);
    wait_ready("t1_ready", 0);
    fd_read(0, 5*512 + 1, d8);
    check("t1_data", d8, pat(5, 1));

    // Dirty track change: write-back LBAs 0..12, then read 13..25
    clear_log();
    fd_write(0, 'h100, 8'ha5);
    fd_read(0, 'h100, d8);
    check("t2_readback", d8, 8'ha5);
    track[5:0] = 6'd1;
    wait_log("t2_len", 26);
    check_seq("t2_wb", 0, 13, 1'b1, 0, 0);
    check_seq("t2_rd", 13, 13, 1'b0, 0, 13);
    check("t2_wb_byte", wb[0*512 + 'h100], 8'ha5);
    check("t2_wb_other", wb[1*512 + 'h100], pat(1, 'h100));
    wait_ready("t2_ready", 0);
    fd_read(0, 0, d8);
    check("t2_new_data", d8, pat(13, 0));

    // Idle flush: counter reaches FLUSH on the 100th clock after the write,
    // the request is registered one clock later
    clear_log();
    @(negedge clk);
    fd_drive      = 1'b0;
    fd_track_addr = 13'h001;
    fd_data_do    = 8'h5a;
    fd_write_disk = 1'b1;
    @(posedge clk); #1;
    fd_write_disk = 1'b0;
    cnt = 0;
    while (sd_wr[0] !== 1'b1 && cnt < 300) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("t3_flush_delay", cnt, FLUSH + 1);
    wait_log("t3_len", 13);
    check_seq("t3_wb", 0, 13, 1'b1, 0, 13);
    check("t3_wb_byte", wb[13*512 + 1], 8'h5a);
    check("t3_wb_keep", wb[13*512 + 0], pat(13, 0));
    wait_ready("t3_ready", 0);
    repeat (200) @(negedge clk);
    check("t3_no_read", log_wr.size(), 13);

    // Write-protected drive 1: write ignored, track change only reads
    clear_log();
    wprot[1] = 1'b1;
    mount(1, SIZE);
    wait_log("t4_load_len", 13);
    check_seq("t4_load", 0, 13, 1'b0, 1, 0);
    wait_ready("t4_load_ready", 1);
    clear_log();
    fd_write(1, 'h100, 8'h77);
    fd_read(1, 'h100, d8);
    check("t4_ram_kept", d8, pat(0, 'h100));
    track[11:6] = 6'd2;
    wait_log("t4_len", 13);
    check_seq("t4_rd_only", 0, 13, 1'b0, 1, 26);
    wait_ready("t4_ready", 1);
    repeat (150) @(negedge clk);
    check("t4_no_wb", log_wr.size(), 13);

    // Both drives change in the same clock: drive 0 first, then drive 1
    clear_log();
    @(negedge clk) track = {6'd4, 6'd3};
    wait_log("t5_len", 26);
    check_seq("t5_d0", 0, 13, 1'b0, 0, 39);
    check_seq("t5_d1", 13, 13, 1'b0, 1, 52);
    wait_ready("t5_ready0", 0);
    wait_ready("t5_ready1", 1);

    // Reset in the middle of sector 5, then clean reload after remount
    clear_log();
    @(negedge clk) track[5:0] = 6'd5;
    wait_log("t6_pre", 5);
    cnt = 0;
    while (sd_ack[0] !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("t6_in_sector5", sd_ack[0], 1);
    @(negedge clk) reset = 1'b1;
    #1;
    check("t6_rst_rd", sd_rd, 0);
    check("t6_rst_wr", sd_wr, 0);
    check("t6_rst_lba", sd_lba, 0);
    check("t6_rst_wait", cpu_wait, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    while (sd_busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("t6_sd_idle", sd_busy, 0);
    clear_log();
    mount(0, SIZE);
    wait_log("t6_len", 13);
    check_seq("t6_reload", 0, 13, 1'b0, 0, 65);
    wait_ready("t6_ready", 0);
    fd_read(0, 5*512 + 1, d8);
    check("t6_data_s5", d8, pat(70, 1));
    fd_read(0, 12*512 + 'h1ff, d8);
    check("t6_data_s12", d8, pat(77, 'h1ff));

    check("sd_onehot", onehot_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
